// File: rtl/guess_sequencer.sv
// Game-flow controller for the 3-digit guess game: entry buffer, answer/guess commit,
// A/B scoring, try counting and WIN/LOSE decision.
module guess_sequencer #(
    parameter int unsigned MAX_TRIES = 10,
    parameter int unsigned TRY_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_val,
    input  logic             key_valid,
    input  logic             key_clr,
    input  logic             key_enter,
    output logic [3:0]       ent1,
    output logic [3:0]       ent2,
    output logic [3:0]       ent3,
    output logic [1:0]       ent_cnt,
    output logic [3:0]       guess1,
    output logic [3:0]       guess2,
    output logic [3:0]       guess3,
    output logic             ans_set,
    output logic [1:0]       a_cnt,
    output logic [1:0]       b_cnt,
    output logic             res_valid,
    output logic [TRY_W-1:0] tries,
    output logic             win,
    output logic             lose,
    output logic             err,
    output logic [2:0]       state
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        SET_ANS = 3'd0,
        PLAY    = 3'd1,
        EVAL    = 3'd2,
        WIN     = 3'd3,
        LOSE    = 3'd4
    } state_e;

    typedef logic [2:0][DIG_W-1:0] trio_t;

    state_e           state_q, state_d;
    trio_t            ent_q, ent_d;
    trio_t            guess_q, guess_d;
    trio_t            ans_q, ans_d;
    logic [CNT_W-1:0] ent_cnt_q, ent_cnt_d;
    logic             ans_set_q, ans_set_d;
    logic [1:0]       a_cnt_q, a_cnt_d;
    logic [1:0]       b_cnt_q, b_cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             err_q, err_d;

    logic             entry_ok;
    logic [1:0]       a_calc;
    logic [1:0]       b_calc;
    logic [TRY_W-1:0] tries_inc;

    // Scoring and entry validation against the registered guess/answer/buffer
    always_comb begin
        entry_ok  = (ent_cnt_q == CNT_W'(3)) &&
                    (ent_q[0] != ent_q[1]) && (ent_q[0] != ent_q[2]) && (ent_q[1] != ent_q[2]);
        a_calc    = 2'(guess_q[0] == ans_q[0]) + 2'(guess_q[1] == ans_q[1]) +
                    2'(guess_q[2] == ans_q[2]);
        b_calc    = 2'(guess_q[0] == ans_q[1]) + 2'(guess_q[0] == ans_q[2]) +
                    2'(guess_q[1] == ans_q[0]) + 2'(guess_q[1] == ans_q[2]) +
                    2'(guess_q[2] == ans_q[0]) + 2'(guess_q[2] == ans_q[1]);
        tries_inc = tries_q + TRY_W'(1);
    end

    // Next-state and next-output logic; key priority clr > enter > digit
    always_comb begin
        state_d     = state_q;
        ent_d       = ent_q;
        ent_cnt_d   = ent_cnt_q;
        guess_d     = guess_q;
        ans_d       = ans_q;
        ans_set_d   = ans_set_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        res_valid_d = 1'b0;
        tries_d     = tries_q;
        win_d       = win_q;
        lose_d      = lose_q;
        err_d       = 1'b0;

        case (state_q)
            SET_ANS, PLAY: begin
                if (key_clr) begin
                    ent_d     = '0;
                    ent_cnt_d = '0;
                end else if (key_enter) begin
                    if (entry_ok) begin
                        ent_d     = '0;
                        ent_cnt_d = '0;
                        if (state_q == SET_ANS) begin
                            ans_d     = ent_q;
                            ans_set_d = 1'b1;
                            tries_d   = '0;
                            a_cnt_d   = '0;
                            b_cnt_d   = '0;
                            state_d   = PLAY;
                        end else begin
                            guess_d = ent_q;
                            state_d = EVAL;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (key_valid) begin
                    if (key_val > 4'd9) begin
                        err_d = 1'b1;
                    end else if (ent_cnt_q != CNT_W'(3)) begin
                        case (ent_cnt_q)
                            2'd0:    ent_d[0] = key_val;
                            2'd1:    ent_d[1] = key_val;
                            2'd2:    ent_d[2] = key_val;
                            default: ;
                        endcase
                        ent_cnt_d = ent_cnt_q + CNT_W'(1);
                    end
                end
            end
            EVAL: begin
                a_cnt_d     = a_calc;
                b_cnt_d     = b_calc;
                tries_d     = tries_inc;
                res_valid_d = 1'b1;
                if (a_calc == 2'd3) begin
                    win_d   = 1'b1;
                    state_d = WIN;
                end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
                    lose_d  = 1'b1;
                    state_d = LOSE;
                end else begin
                    state_d = PLAY;
                end
            end
            WIN, LOSE: begin
                if (!key_clr && key_enter) begin
                    state_d   = SET_ANS;
                    ans_set_d = 1'b0;
                    ans_d     = '0;
                    guess_d   = '0;
                    tries_d   = '0;
                    a_cnt_d   = '0;
                    b_cnt_d   = '0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                end
            end
            default: state_d = SET_ANS;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SET_ANS;
            ent_q       <= '0;
            ent_cnt_q   <= '0;
            guess_q     <= '0;
            ans_q       <= '0;
            ans_set_q   <= 1'b0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            res_valid_q <= 1'b0;
            tries_q     <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ent_q       <= ent_d;
            ent_cnt_q   <= ent_cnt_d;
            guess_q     <= guess_d;
            ans_q       <= ans_d;
            ans_set_q   <= ans_set_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            res_valid_q <= res_valid_d;
            tries_q     <= tries_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            err_q       <= err_d;
        end
    end

    assign ent1      = ent_q[0];
    assign ent2      = ent_q[1];
    assign ent3      = ent_q[2];
    assign ent_cnt   = ent_cnt_q;
    assign guess1    = guess_q[0];
    assign guess2    = guess_q[1];
    assign guess3    = guess_q[2];
    assign ans_set   = ans_set_q;
    assign a_cnt     = a_cnt_q;
    assign b_cnt     = b_cnt_q;
    assign res_valid = res_valid_q;
    assign tries     = tries_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_guess_sequencer.sv
// Directed bench for guess_sequencer with a scoreboard of expected guess results.
module tb_guess_sequencer;

    localparam int unsigned MAX_T = 3;
    localparam int unsigned TW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    key_val = '0;
    logic          key_valid = 1'b0;
    logic          key_clr = 1'b0;
    logic          key_enter = 1'b0;
    logic [3:0]    ent1, ent2, ent3, guess1, guess2, guess3;
    logic [1:0]    ent_cnt, a_cnt, b_cnt;
    logic          ans_set, res_valid, win, lose, err;
    logic [TW-1:0] tries;
    logic [2:0]    state;

    guess_sequencer #(.MAX_TRIES(MAX_T), .TRY_W(TW)) dut (
        .clk(clk), .reset(reset), .key_val(key_val), .key_valid(key_valid),
        .key_clr(key_clr), .key_enter(key_enter),
        .ent1(ent1), .ent2(ent2), .ent3(ent3), .ent_cnt(ent_cnt),
        .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .ans_set(ans_set), .a_cnt(a_cnt), .b_cnt(b_cnt), .res_valid(res_valid),
        .tries(tries), .win(win), .lose(lose), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] t;
        logic       w;
        logic       l;
        logic [2:0] st;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] m_ans0, m_ans1, m_ans2;
    int         m_tries = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        key_val   = v;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_val   = '0;
    endtask

    task automatic enter();
        @(negedge clk);
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
    endtask

    task automatic type3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        press(d0);
        press(d1);
        press(d2);
    endtask

    task automatic set_answer(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        type3(d0, d1, d2);
        enter();
        m_ans0  = d0;
        m_ans1  = d1;
        m_ans2  = d2;
        m_tries = 0;
        chk("ans_set", 32'(ans_set), 32'd1);
        chk("ans_state", 32'(state), 32'd1);
    endtask

    // Commit a guess, push the modelled result, then pop it when res_valid fires
    task automatic guess(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2);
        exp_t e;
        exp_t got_e;
        bit   seen;
        int   a;
        int   b;
        type3(d0, d1, d2);
        a = int'(d0 == m_ans0) + int'(d1 == m_ans1) + int'(d2 == m_ans2);
        b = int'(d0 == m_ans1) + int'(d0 == m_ans2) + int'(d1 == m_ans0) +
            int'(d1 == m_ans2) + int'(d2 == m_ans0) + int'(d2 == m_ans1);
        m_tries++;
        e.a  = 2'(a);
        e.b  = 2'(b);
        e.t  = 4'(m_tries);
        e.w  = (a == 3);
        e.l  = (a != 3) && (m_tries == int'(MAX_T));
        e.st = e.w ? 3'd3 : (e.l ? 3'd4 : 3'd1);
        exp_q.push_back(e);
        enter();
        chk({tag, "_eval"}, 32'(state), 32'd2);
        chk({tag, "_guess"}, {20'd0, guess1, guess2, guess3}, {20'd0, d0, d1, d2});
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk({tag, "_res_valid"}, 32'(seen), 32'd1);
        got_e = exp_q.pop_front();
        if (seen) begin
            chk({tag, "_a"}, 32'(a_cnt), 32'(got_e.a));
            chk({tag, "_b"}, 32'(b_cnt), 32'(got_e.b));
            chk({tag, "_tries"}, 32'(tries), 32'(got_e.t));
            chk({tag, "_win"}, 32'(win), 32'(got_e.w));
            chk({tag, "_lose"}, 32'(lose), 32'(got_e.l));
            chk({tag, "_state"}, 32'(state), 32'(got_e.st));
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(res_valid), 32'd0);
    endtask

    task automatic restart(input string tag);
        enter();
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_ans_set"}, 32'(ans_set), 32'd0);
        chk({tag, "_tries"}, 32'(tries), 32'd0);
        chk({tag, "_guess"}, 32'(guess1), 32'd0);
        chk({tag, "_flags"}, {30'd0, win, lose}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ent_cnt", 32'(ent_cnt), 32'd0);
        chk("rst_ans_set", 32'(ans_set), 32'd0);
        chk("rst_tries", 32'(tries), 32'd0);
        chk("rst_flags", {27'd0, res_valid, win, lose, err, 1'b0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Guess equals the answer: immediate win
        set_answer(4'd1, 4'd2, 4'd3);
        chk("ent_cleared", 32'(ent_cnt), 32'd0);
        guess("win1", 4'd1, 4'd2, 4'd3);
        press(4'd5);
        chk("win_digit_ignored", 32'(ent_cnt), 32'd0);
        restart("rst_win");

        // Two cross matches, back to PLAY
        set_answer(4'd4, 4'd5, 4'd6);
        guess("b2", 4'd6, 4'd4, 4'd7);

        // Entry validation
        type3(4'd1, 4'd1, 4'd2);
        chk("dup_cnt", 32'(ent_cnt), 32'd3);
        chk("dup_digits", {20'd0, ent1, ent2, ent3}, 32'h112);
        enter();
        chk("dup_err", 32'(err), 32'd1);
        chk("dup_keep", 32'(ent_cnt), 32'd3);
        chk("dup_state", 32'(state), 32'd1);
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd0);
        press(4'd12);
        chk("bad_key_err", 32'(err), 32'd1);
        press(4'd7);
        chk("full_no_err", 32'(err), 32'd0);
        chk("full_cnt", 32'(ent_cnt), 32'd3);
        chk("full_ent3", 32'(ent3), 32'd2);

        // Clear beats enter in the same cycle
        @(negedge clk);
        key_clr = 1'b1;
        @(negedge clk);
        key_clr = 1'b0;
        type3(4'd7, 4'd8, 4'd9);
        @(negedge clk);
        key_clr   = 1'b1;
        key_enter = 1'b1;
        @(negedge clk);
        key_clr   = 1'b0;
        key_enter = 1'b0;
        chk("clr_cnt", 32'(ent_cnt), 32'd0);
        chk("clr_ent", {20'd0, ent1, ent2, ent3}, 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_tries", 32'(tries), 32'd1);

        // Mixed score then exhaust tries
        guess("mix", 4'd5, 4'd4, 4'd6);
        guess("lose3", 4'd1, 4'd2, 4'd3);
        restart("rst_lose");

        // Three misses -> LOSE at MAX_TRIES
        set_answer(4'd0, 4'd1, 4'd2);
        guess("m1", 4'd3, 4'd4, 4'd5);
        guess("m2", 4'd3, 4'd4, 4'd5);
        guess("m3", 4'd3, 4'd4, 4'd5);
        restart("rst_lose2");

        // WIN on the final try has priority over LOSE
        set_answer(4'd0, 4'd1, 4'd2);
        guess("w1", 4'd3, 4'd4, 4'd5);
        guess("w2", 4'd0, 4'd2, 4'd1);
        guess("w3", 4'd0, 4'd1, 4'd2);
        restart("rst_win2");

        // Reset asserted while in EVAL
        set_answer(4'd1, 4'd2, 4'd3);
        type3(4'd3, 4'd2, 4'd1);
        enter();
        chk("pre_rst_eval", 32'(state), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_ans_set", 32'(ans_set), 32'd0);
        chk("async_score", {28'd0, a_cnt, b_cnt}, 32'd0);
        chk("async_tries", 32'(tries), 32'd0);
        chk("async_guess", {20'd0, guess1, guess2, guess3}, 32'd0);
        repeat (2) @(negedge clk);
        chk("held_res_valid", {29'd0, res_valid, win, lose}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        set_answer(4'd9, 4'd8, 4'd7);
        guess("post_rst", 4'd9, 4'd7, 4'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
